// File: rtl/game_sequencer_pkg.sv
// game_sequencer_pkg
// Shared definitions for the snake cartridge sequencer:
//   - game state codes (values are visible on game_state)
//   - direction codes LEFT_DIR/TOP_DIR/RIGHT_DIR/DOWN_DIR
//   - TAIL_SIZE, the width of the tail length bus from game_logic
//   - direction helpers (reverse, lowest-index edge select)
package game_sequencer_pkg;

  localparam int TAIL_SIZE = 8;

  typedef enum logic [2:0] {
    STATE_IDLE   = 3'd0,
    STATE_INGAME = 3'd1,
    STATE_PAUSE  = 3'd2,
    STATE_OVER   = 3'd3,
    STATE_WON    = 3'd4,
    STATE_TEST   = 3'd5
  } state_e;

  localparam logic [1:0] LEFT_DIR  = 2'd0;
  localparam logic [1:0] TOP_DIR   = 2'd1;
  localparam logic [1:0] RIGHT_DIR = 2'd2;
  localparam logic [1:0] DOWN_DIR  = 2'd3;

  // Opposite heading: flipping bit 1 swaps LEFT<->RIGHT and TOP<->DOWN.
  function automatic logic [1:0] reverse_dir(input logic [1:0] dir);
    return dir ^ 2'b10;
  endfunction

  // Bit i of the edge vector is direction code i; the lowest set bit wins.
  function automatic logic [1:0] first_dir(input logic [3:0] edges);
    logic [1:0] dir;
    casez (edges)
      4'b???1: dir = LEFT_DIR;
      4'b??10: dir = TOP_DIR;
      4'b?100: dir = RIGHT_DIR;
      default: dir = DOWN_DIR;
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/game_sequencer_dir_queue.sv
// dir_queue
// Two-entry FIFO of pending snake headings with a turn filter.
// A pushed heading is kept only if it differs from the reference heading
// (the newest queued entry, or cur_dir when empty), is not its reverse,
// and the queue is not full. pop moves the head out; flush empties it.
// Ports:
//   clk, reset_n        clock and synchronous active-low reset
//   flush               empty the queue (new game)
//   push_valid/push_dir candidate heading
//   pop                 remove head (ignored when empty)
//   cur_dir             heading currently applied, reference when empty
//   head, not_empty     oldest entry and occupancy flag
module dir_queue
  import game_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       push_valid,
  input  logic [1:0] push_dir,
  input  logic       pop,
  input  logic [1:0] cur_dir,
  output logic [1:0] head,
  output logic       not_empty
);

  logic [1:0] entry0_r;
  logic [1:0] entry1_r;
  logic [1:0] count_r;
  logic [1:0] ref_s;
  logic       accept_s;
  logic       pop_s;

  // Push filter against the pre-pop reference, and effective pop
  always_comb begin
    case (count_r)
      2'd1:    ref_s = entry0_r;
      2'd2:    ref_s = entry1_r;
      default: ref_s = cur_dir;
    endcase
    if (push_valid && (count_r != 2'd2) && (push_dir != ref_s) &&
        (push_dir != reverse_dir(ref_s))) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    pop_s = pop && (count_r != 2'd0);
  end

  // Queue storage and occupancy
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      count_r  <= 2'd0;
      entry0_r <= RIGHT_DIR;
      entry1_r <= RIGHT_DIR;
    end else begin
      case ({accept_s, pop_s})
        2'b01: begin
          entry0_r <= entry1_r;
          count_r  <= count_r - 2'd1;
        end
        2'b10: begin
          if (count_r == 2'd0) begin
            entry0_r <= push_dir;
          end else begin
            entry1_r <= push_dir;
          end
          count_r <= count_r + 2'd1;
        end
        // Only reachable with one entry: it leaves, the new one becomes head.
        2'b11:   entry0_r <= push_dir;
        default: count_r  <= count_r;
      endcase
    end
  end

  assign head      = entry0_r;
  assign not_empty = (count_r != 2'd0);

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer
// Top-level controller of the snake cartridge: game FSM, game-step tick
// generation from video frames, new-game reset pulse for game_logic,
// direction queue feeding and best-tail tracking.
// Ports:
//   vga_clk, reset_n       clock, synchronous active-low reset
//   frame_start            one-cycle pulse per video frame
//   btn_start/pause/test   debounced button levels
//   btn_dir[3:0]           debounced direction levels, bit i = direction code i
//                          (0 LEFT, 1 TOP, 2 RIGHT, 3 DOWN)
//   game_over, game_won    status from game_logic
//   tail_count             current tail length from game_logic
//   game_state             state code (IDLE 0 .. TEST 5)
//   direction              heading applied for the current step
//   update_tick            one-cycle game-step strobe
//   logic_reset_p          active-high reset to game_logic
//   best_tail              highest tail_count seen since reset_n
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int TICK_FRAMES = 4,
  parameter int RST_CYCLES  = 4
) (
  input  logic                 vga_clk,
  input  logic                 reset_n,
  input  logic                 frame_start,
  input  logic                 btn_start,
  input  logic                 btn_pause,
  input  logic                 btn_test,
  input  logic [3:0]           btn_dir,
  input  logic                 game_over,
  input  logic                 game_won,
  input  logic [TAIL_SIZE-1:0] tail_count,
  output logic [2:0]           game_state,
  output logic [1:0]           direction,
  output logic                 update_tick,
  output logic                 logic_reset_p,
  output logic [TAIL_SIZE-1:0] best_tail
);

  localparam logic [7:0] TICK_LAST = 8'(TICK_FRAMES - 1);
  localparam logic [3:0] RST_LOAD  = 4'(RST_CYCLES - 1);

  state_e     state_r;
  state_e     state_next_s;
  logic       new_game_s;
  logic       in_game_s;
  logic       hold_reset_s;
  logic       frame_adv_s;
  logic       tick_fire_s;
  logic       push_valid_s;
  logic [1:0] push_dir_s;
  logic       start_prev_r;
  logic       pause_prev_r;
  logic [3:0] dir_prev_r;
  logic       start_edge_s;
  logic       pause_edge_s;
  logic [3:0] dir_edge_s;
  logic [7:0] frame_cnt_r;
  logic [3:0] rst_cnt_r;
  logic [1:0] q_head_s;
  logic       q_not_empty_s;

  // Previous button levels for rising-edge detection
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      start_prev_r <= 1'b0;
      pause_prev_r <= 1'b0;
      dir_prev_r   <= 4'd0;
    end else begin
      start_prev_r <= btn_start;
      pause_prev_r <= btn_pause;
      dir_prev_r   <= btn_dir;
    end
  end

  assign start_edge_s = btn_start & ~start_prev_r;
  assign pause_edge_s = btn_pause & ~pause_prev_r;
  assign dir_edge_s   = btn_dir & ~dir_prev_r;

  // FSM state register
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state_r <= STATE_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state; new_game_s marks transitions that restart game_logic
  always_comb begin
    state_next_s = state_r;
    new_game_s   = 1'b0;
    case (state_r)
      STATE_IDLE: begin
        if (btn_test) begin
          state_next_s = STATE_TEST;
        end else if (start_edge_s) begin
          state_next_s = STATE_INGAME;
          new_game_s   = 1'b1;
        end else begin
          state_next_s = STATE_IDLE;
        end
      end
      STATE_INGAME: begin
        // A collision reported during the reset pulse is stale.
        if (game_over && !logic_reset_p) begin
          state_next_s = STATE_OVER;
        end else if (game_won) begin
          state_next_s = STATE_WON;
        end else if (pause_edge_s) begin
          state_next_s = STATE_PAUSE;
        end else begin
          state_next_s = STATE_INGAME;
        end
      end
      STATE_PAUSE: begin
        if (pause_edge_s || start_edge_s) begin
          state_next_s = STATE_INGAME;
        end else begin
          state_next_s = STATE_PAUSE;
        end
      end
      STATE_OVER, STATE_WON: begin
        if (start_edge_s) begin
          state_next_s = STATE_INGAME;
          new_game_s   = 1'b1;
        end else begin
          state_next_s = state_r;
        end
      end
      STATE_TEST: begin
        if (!btn_test) begin
          state_next_s = STATE_IDLE;
        end else begin
          state_next_s = STATE_TEST;
        end
      end
      default: state_next_s = STATE_IDLE;
    endcase
  end

  // FSM output decode: qualifiers for counters, queue and reset pulse
  always_comb begin
    in_game_s    = (state_r == STATE_INGAME);
    hold_reset_s = (state_next_s == STATE_IDLE) || (state_next_s == STATE_TEST);
    frame_adv_s  = in_game_s && !logic_reset_p && frame_start;
    tick_fire_s  = frame_adv_s && (frame_cnt_r == TICK_LAST);
    push_valid_s = in_game_s && (dir_edge_s != 4'd0);
    push_dir_s   = first_dir(dir_edge_s);
  end

  assign game_state = state_r;

  // Frame counter and game-step strobe
  always_ff @(posedge vga_clk) begin
    if (!reset_n || new_game_s) begin
      frame_cnt_r <= 8'd0;
      update_tick <= 1'b0;
    end else begin
      update_tick <= tick_fire_s;
      if (tick_fire_s) begin
        frame_cnt_r <= 8'd0;
      end else if (frame_adv_s) begin
        frame_cnt_r <= frame_cnt_r + 8'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
    end
  end

  // game_logic reset: RST_CYCLES high from a new game, and always in IDLE/TEST
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      rst_cnt_r     <= 4'd0;
      logic_reset_p <= 1'b1;
    end else if (new_game_s) begin
      rst_cnt_r     <= RST_LOAD;
      logic_reset_p <= 1'b1;
    end else if (hold_reset_s) begin
      rst_cnt_r     <= 4'd0;
      logic_reset_p <= 1'b1;
    end else if (rst_cnt_r != 4'd0) begin
      rst_cnt_r     <= rst_cnt_r - 4'd1;
      logic_reset_p <= 1'b1;
    end else begin
      logic_reset_p <= 1'b0;
    end
  end

  // Applied heading: takes the queue head on each game step
  always_ff @(posedge vga_clk) begin
    if (!reset_n || new_game_s) begin
      direction <= RIGHT_DIR;
    end else if (tick_fire_s && q_not_empty_s) begin
      direction <= q_head_s;
    end else begin
      direction <= direction;
    end
  end

  // Best tail length, cleared only by reset_n
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      best_tail <= '0;
    end else if (in_game_s && (tail_count > best_tail)) begin
      best_tail <= tail_count;
    end else begin
      best_tail <= best_tail;
    end
  end

  dir_queue u_dir_queue (
    .clk        (vga_clk),
    .reset_n    (reset_n),
    .flush      (new_game_s),
    .push_valid (push_valid_s),
    .push_dir   (push_dir_s),
    .pop        (tick_fire_s),
    .cur_dir    (direction),
    .head       (q_head_s),
    .not_empty  (q_not_empty_s)
  );

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed scenarios plus a
// randomized run compared against a behavioural model of the game rules.
module tb_game_sequencer;
  import game_sequencer_pkg::TAIL_SIZE;

  localparam int TICK_FRAMES = 4;
  localparam int RST_CYCLES  = 4;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 frame_start = 1'b0;
  logic                 btn_start = 1'b0;
  logic                 btn_pause = 1'b0;
  logic                 btn_test = 1'b0;
  logic [3:0]           btn_dir = 4'd0;
  logic                 game_over = 1'b0;
  logic                 game_won = 1'b0;
  logic [TAIL_SIZE-1:0] tail_count = '0;
  logic [2:0]           game_state;
  logic [1:0]           direction;
  logic                 update_tick;
  logic                 logic_reset_p;
  logic [TAIL_SIZE-1:0] best_tail;

  int checks = 0;
  int errors = 0;

  // Behavioural model
  logic [2:0]           m_state;
  logic [1:0]           m_dir;
  logic                 m_tick;
  logic                 m_rstp;
  logic [TAIL_SIZE-1:0] m_best;
  logic [1:0]           dq[$];
  int                   m_frames;
  int                   m_entry;
  int                   cyc = 0;
  logic                 p_start, p_pause;
  logic [3:0]           p_dir;

  game_sequencer #(.TICK_FRAMES(TICK_FRAMES), .RST_CYCLES(RST_CYCLES)) dut (
    .vga_clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .btn_start(btn_start), .btn_pause(btn_pause), .btn_test(btn_test),
    .btn_dir(btn_dir), .game_over(game_over), .game_won(game_won),
    .tail_count(tail_count), .game_state(game_state), .direction(direction),
    .update_tick(update_tick), .logic_reset_p(logic_reset_p), .best_tail(best_tail)
  );

  always #5 clk = ~clk;

  // Apply the game rules to the inputs seen at this clock edge.
  task automatic model_update();
    logic [2:0] ns;
    logic [1:0] nd, rf;
    logic [3:0] de;
    bit ng, se, pe, have, push, tk;
    if (!reset_n) begin
      m_state = 3'd0; m_dir = 2'd2; m_tick = 1'b0; m_rstp = 1'b1; m_best = '0;
      dq.delete(); m_frames = 0; m_entry = -100;
      p_start = 1'b0; p_pause = 1'b0; p_dir = 4'd0;
    end else begin
      se = btn_start && !p_start;
      pe = btn_pause && !p_pause;
      ns = m_state; ng = 0;
      case (m_state)
        3'd0: if (btn_test) ns = 3'd5; else if (se) begin ns = 3'd1; ng = 1; end
        3'd1: if (game_over && !m_rstp) ns = 3'd3; else if (game_won) ns = 3'd4;
              else if (pe) ns = 3'd2;
        3'd2: if (pe || se) ns = 3'd1;
        3'd3, 3'd4: if (se) begin ns = 3'd1; ng = 1; end
        3'd5: if (!btn_test) ns = 3'd0;
        default: ns = 3'd0;
      endcase
      tk = 0;
      if (m_state == 3'd1 && !m_rstp && frame_start) begin
        m_frames++;
        tk = (m_frames % TICK_FRAMES) == 0;
      end
      de = btn_dir & ~p_dir;
      have = 0; nd = 2'd0;
      for (int i = 3; i >= 0; i--) if (de[i]) begin have = 1; nd = 2'(i); end
      push = 0;
      if (m_state == 3'd1 && have) begin
        rf = (dq.size() > 0) ? dq[$] : m_dir;
        push = (nd != rf) && (nd != (rf ^ 2'b10)) && (dq.size() < 2);
      end
      if (tk && dq.size() > 0) m_dir = dq.pop_front();
      if (push) dq.push_back(nd);
      if (m_state == 3'd1 && tail_count > m_best) m_best = tail_count;
      if (ng) begin dq.delete(); m_dir = 2'd2; m_frames = 0; m_entry = cyc; end
      m_tick = tk;
      m_state = ns;
      m_rstp = (ns == 3'd0 || ns == 3'd5) ? 1'b1 : ((cyc - m_entry) < RST_CYCLES);
      p_start = btn_start; p_pause = btn_pause; p_dir = btn_dir;
    end
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic frame(output logic t, output logic [1:0] d);
    frame_start = 1'b1; step();
    t = update_tick; d = direction;
    frame_start = 1'b0; step();
  endtask

  // Feed frames until a tick appears (bounded); report heading at the tick.
  task automatic next_tick(output bit got, output logic [1:0] d);
    logic t;
    logic [1:0] dd;
    got = 0; d = 2'd0;
    for (int i = 0; i < 2 * TICK_FRAMES && !got; i++) begin
      frame(t, dd);
      if (t) begin got = 1; d = dd; end
    end
  endtask

  task automatic press(input int b);
    btn_dir = 4'd0; btn_dir[b] = 1'b1; step();
    btn_dir = 4'd0; step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step();
    checks++;
    if ({game_state, direction, update_tick, logic_reset_p, best_tail} !==
        {3'd0, 2'd2, 1'b0, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL reset_values: got state=%0d dir=%0d tick=%0d rstp=%0d best=%0d expected 0/2/0/1/0",
               game_state, direction, update_tick, logic_reset_p, best_tail);
    end
    reset_n = 1'b1; step();
  endtask

  task automatic test_test_mode();
    btn_test = 1'b1; step();
    checks++;
    if (game_state !== 3'd5 || logic_reset_p !== 1'b1) begin
      errors++; $display("FAIL test_enter: got state=%0d rstp=%0d expected 5/1", game_state, logic_reset_p);
    end
    btn_test = 1'b0; step();
    checks++;
    if (game_state !== 3'd0) begin
      errors++; $display("FAIL test_exit: got state=%0d expected 0", game_state);
    end
  endtask

  task automatic test_start();
    int hi;
    logic t;
    logic [1:0] d;
    btn_start = 1'b1; step();
    checks++;
    if (game_state !== 3'd1 || logic_reset_p !== 1'b1) begin
      errors++; $display("FAIL start_state: got state=%0d rstp=%0d expected 1/1", game_state, logic_reset_p);
    end
    btn_start = 1'b0;
    hi = 1;
    for (int i = 0; i < 12 && logic_reset_p; i++) begin
      step();
      if (logic_reset_p) hi++;
    end
    checks++;
    if (hi != RST_CYCLES) begin
      errors++; $display("FAIL reset_pulse_len: got %0d cycles expected %0d", hi, RST_CYCLES);
    end
    for (int f = 1; f <= TICK_FRAMES; f++) begin
      frame(t, d);
      checks++;
      if (t !== (f == TICK_FRAMES)) begin
        errors++; $display("FAIL first_tick frame %0d: got tick=%0d expected %0d", f, t, f == TICK_FRAMES);
      end
    end
  endtask

  task automatic test_dir_queue();
    bit got;
    logic [1:0] d;
    press(1); press(0);                         // TOP then LEFT
    next_tick(got, d);
    checks++;
    if (!got || d !== 2'd1) begin errors++; $display("FAIL queue_tick1: got %0d/%0d expected 1/1", got, d); end
    next_tick(got, d);
    checks++;
    if (!got || d !== 2'd0) begin errors++; $display("FAIL queue_tick2: got %0d/%0d expected 1/0", got, d); end
    press(1);                                   // TOP
    next_tick(got, d);
    press(2);                                   // RIGHT, accepted after TOP
    press(0);                                   // LEFT, reverse of RIGHT reference
    next_tick(got, d);
    checks++;
    if (!got || d !== 2'd2) begin errors++; $display("FAIL queue_right: got %0d/%0d expected 1/2", got, d); end
    next_tick(got, d);
    checks++;
    if (!got || d !== 2'd2) begin errors++; $display("FAIL reverse_drop: got %0d/%0d expected 1/2", got, d); end
  endtask

  task automatic test_overflow();
    bit got;
    logic [1:0] d;
    press(1); press(0); press(3);               // TOP, LEFT, DOWN
    next_tick(got, d);
    checks++;
    if (!got || d !== 2'd1) begin errors++; $display("FAIL overflow_tick1: got %0d/%0d expected 1/1", got, d); end
    next_tick(got, d);
    checks++;
    if (!got || d !== 2'd0) begin errors++; $display("FAIL overflow_tick2: got %0d/%0d expected 1/0", got, d); end
    next_tick(got, d);
    checks++;
    if (!got || d !== 2'd0) begin errors++; $display("FAIL overflow_drop: got %0d/%0d expected 1/0", got, d); end
  endtask

  task automatic test_pause();
    logic t;
    logic [1:0] d;
    int ticks;
    frame(t, d); frame(t, d);
    btn_pause = 1'b1; step();
    checks++;
    if (game_state !== 3'd2) begin errors++; $display("FAIL pause_enter: got %0d expected 2", game_state); end
    btn_pause = 1'b0; step();
    ticks = 0;
    repeat (10) begin frame(t, d); if (t) ticks++; end
    checks++;
    if (ticks != 0) begin errors++; $display("FAIL pause_ticks: got %0d expected 0", ticks); end
    btn_pause = 1'b1; step(); btn_pause = 1'b0; step();
    checks++;
    if (game_state !== 3'd1) begin errors++; $display("FAIL pause_resume: got %0d expected 1", game_state); end
    frame(t, d);
    checks++;
    if (t !== 1'b0) begin errors++; $display("FAIL resume_frame1: got tick=%0d expected 0", t); end
    frame(t, d);
    checks++;
    if (t !== 1'b1) begin errors++; $display("FAIL resume_frame2: got tick=%0d expected 1", t); end
  endtask

  task automatic test_game_over_restart();
    bit got;
    logic [1:0] d;
    press(1);                                   // TOP queued, must be flushed
    game_over = 1'b1; step();
    checks++;
    if (game_state !== 3'd3) begin errors++; $display("FAIL over_state: got %0d expected 3", game_state); end
    game_over = 1'b0; step();
    btn_start = 1'b1; game_over = 1'b1; step();
    checks++;
    if (game_state !== 3'd1 || direction !== 2'd2) begin
      errors++; $display("FAIL restart: got state=%0d dir=%0d expected 1/2", game_state, direction);
    end
    btn_start = 1'b0;
    for (int i = 0; i < 12 && logic_reset_p; i++) begin
      step();
      checks++;
      if (game_state !== 3'd1) begin errors++; $display("FAIL over_masked: got %0d expected 1", game_state); end
    end
    game_over = 1'b0;
    next_tick(got, d);
    checks++;
    if (!got || d !== 2'd2) begin errors++; $display("FAIL flush_queue: got %0d/%0d expected 1/2", got, d); end
  endtask

  task automatic test_best_tail();
    tail_count = 8'd7; step();
    checks++;
    if (best_tail !== 8'd7) begin errors++; $display("FAIL best_7: got %0d expected 7", best_tail); end
    tail_count = 8'd3; step();
    checks++;
    if (best_tail !== 8'd7) begin errors++; $display("FAIL best_hold: got %0d expected 7", best_tail); end
    tail_count = 8'd0;
    game_over = 1'b1; step(); game_over = 1'b0;
    btn_start = 1'b1; step(); btn_start = 1'b0; step();
    checks++;
    if (best_tail !== 8'd7) begin errors++; $display("FAIL best_newgame: got %0d expected 7", best_tail); end
    reset_n = 1'b0; step();
    checks++;
    if (best_tail !== 8'd0) begin errors++; $display("FAIL best_reset: got %0d expected 0", best_tail); end
    reset_n = 1'b1; step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 4000; n++) begin
      frame_start = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0)  btn_start = ~btn_start;
      if ($urandom_range(0, 11) == 0) btn_pause = ~btn_pause;
      if ($urandom_range(0, 99) == 0) btn_test = ~btn_test;
      if ($urandom_range(0, 2) == 0)  btn_dir = btn_dir ^ 4'($urandom_range(0, 15));
      game_over = ($urandom_range(0, 79) == 0);
      game_won  = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) tail_count = TAIL_SIZE'($urandom_range(0, 255));
      reset_n = ($urandom_range(0, 999) != 0);
      step();
      checks++;
      if ({game_state, direction, update_tick, logic_reset_p, best_tail} !==
          {m_state, m_dir, m_tick, m_rstp, m_best}) begin
        errors++;
        $display("FAIL random cycle %0d: got st=%0d dir=%0d tick=%0d rstp=%0d best=%0d expected %0d/%0d/%0d/%0d/%0d",
                 n, game_state, direction, update_tick, logic_reset_p, best_tail,
                 m_state, m_dir, m_tick, m_rstp, m_best);
      end
    end
  endtask

  initial begin
    test_reset();
    test_test_mode();
    test_start();
    test_dir_queue();
    test_overflow();
    test_pause();
    test_game_over_restart();
    test_best_tail();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
